// File: rtl/leaf_user_bridge_pkg.sv
// Shared types and helpers for the leaf user-side bridge.
package leaf_bridge_pkg;

  typedef enum logic [0:0] {
    RST_WAIT = 1'b0,
    RUN      = 1'b1
  } seq_state_e;

  localparam int START_ALWAYS = 0;
  localparam int START_GATED  = 1;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_user_bridge_if.sv
// Stream bundle between leaf_interface, the bridge and the HLS operator.
// master is the bridge's view; slave is the view of everything around it.
interface leaf_user_bridge_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int N_IN         = 1,
  parameter int N_OUT        = 2
);
  logic [N_IN*PAYLOAD_BITS-1:0]  din_if_data;
  logic [N_IN-1:0]               din_if_vld;
  logic [N_IN-1:0]               din_if_ack;
  logic [N_IN*PAYLOAD_BITS-1:0]  dout_op_data;
  logic [N_IN-1:0]               dout_op_vld;
  logic [N_IN-1:0]               dout_op_ack;
  logic [N_OUT*PAYLOAD_BITS-1:0] din_op_data;
  logic [N_OUT-1:0]              din_op_vld;
  logic [N_OUT-1:0]              din_op_ack;
  logic [N_OUT*PAYLOAD_BITS-1:0] dout_if_data;
  logic [N_OUT-1:0]              dout_if_vld;
  logic [N_OUT-1:0]              dout_if_ack;

  modport master (
    input  din_if_data, din_if_vld, dout_op_ack, din_op_data, din_op_vld, dout_if_ack,
    output din_if_ack, dout_op_data, dout_op_vld, din_op_ack, dout_if_data, dout_if_vld
  );

  modport slave (
    output din_if_data, din_if_vld, dout_op_ack, din_op_data, din_op_vld, dout_if_ack,
    input  din_if_ack, dout_op_data, dout_op_vld, din_op_ack, dout_if_data, dout_if_vld
  );
endinterface

// File: rtl/leaf_user_bridge_chan_fifo.sv
// One elastic channel: FWFT FIFO with registered-only ack and a write counter.
module leaf_chan_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH        = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PAYLOAD_BITS-1:0] i_wr_data,
  input  logic                    i_wr_vld,
  output logic                    o_wr_ack,
  output logic [PAYLOAD_BITS-1:0] o_rd_data,
  output logic                    o_rd_vld,
  input  logic                    i_rd_ack,
  output logic [CNT_BITS-1:0]     o_cnt
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]         PTR_ONE = 1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [CNT_BITS-1:0]     r_cnt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Ack looks only at stored state, so a pop never frees room in the same cycle.
  assign o_wr_ack  = !w_full && !i_rst;
  assign w_push    = i_wr_vld && o_wr_ack;
  assign o_rd_vld  = !w_empty;
  assign w_pop     = o_rd_vld && i_rd_ack;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_cnt     = r_cnt;

  // Pointer and counter update; reset discards anything still queued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_cnt    <= r_cnt + CNT_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; no reset needed because the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/leaf_user_bridge.sv
// Elastic adapter between leaf_interface user ports and HLS ap_vld/ap_ack streams.
//
// state    | meaning
// RST_WAIT | delay timer running after reset; ap_start held low
// RUN      | operator may start (always, or gated on all inputs holding data)
module leaf_user_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int N_IN         = 1,
  parameter int N_OUT        = 2,
  parameter int DEPTH        = 4,
  parameter int START_MODE   = 0,
  parameter int START_DELAY  = 8,
  parameter int CNT_BITS     = 16
) (
  input  logic                               clk_user,
  input  logic                               reset,
  leaf_user_bridge_if.master                 bus,
  output logic                               ap_start,
  output logic [(N_IN+N_OUT)*CNT_BITS-1:0]   xfer_cnt
);
  localparam logic [0:0] ST_RST_WAIT = RST_WAIT;
  localparam logic [0:0] ST_RUN      = RUN;
  localparam logic [7:0] DELAY_INIT  = 8'(START_DELAY);

  logic [N_IN-1:0]               w_in_ack;
  logic [N_IN-1:0]               w_in_vld;
  logic [N_IN*PAYLOAD_BITS-1:0]  w_in_data;
  logic [N_OUT-1:0]              w_out_ack;
  logic [N_OUT-1:0]              w_out_vld;
  logic [N_OUT*PAYLOAD_BITS-1:0] w_out_data;

  logic [0:0] r_state;
  logic [7:0] r_delay;
  logic       r_ap_start;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    leaf_chan_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)
    ) u_fifo (
      .i_clk     (clk_user),
      .i_rst     (reset),
      .i_wr_data (bus.din_if_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_wr_vld  (bus.din_if_vld[i]),
      .o_wr_ack  (w_in_ack[i]),
      .o_rd_data (w_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_rd_vld  (w_in_vld[i]),
      .i_rd_ack  (bus.dout_op_ack[i]),
      .o_cnt     (xfer_cnt[i*CNT_BITS +: CNT_BITS])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    leaf_chan_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)
    ) u_fifo (
      .i_clk     (clk_user),
      .i_rst     (reset),
      .i_wr_data (bus.din_op_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_wr_vld  (bus.din_op_vld[j]),
      .o_wr_ack  (w_out_ack[j]),
      .o_rd_data (w_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_rd_vld  (w_out_vld[j]),
      .i_rd_ack  (bus.dout_if_ack[j]),
      .o_cnt     (xfer_cnt[(N_IN+j)*CNT_BITS +: CNT_BITS])
    );
  end

  assign bus.din_if_ack   = w_in_ack;
  assign bus.dout_op_vld  = w_in_vld;
  assign bus.dout_op_data = w_in_data;
  assign bus.din_op_ack   = w_out_ack;
  assign bus.dout_if_vld  = w_out_vld;
  assign bus.dout_if_data = w_out_data;

  // Start sequencer: down-count the delay, then hold RUN until the next reset.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      r_state    <= ST_RST_WAIT;
      r_delay    <= DELAY_INIT;
      r_ap_start <= 1'b0;
    end else begin
      if (r_state == ST_RST_WAIT) begin
        if (r_delay <= 8'd1) r_state <= ST_RUN;
        else                 r_delay <= r_delay - 8'd1;
      end
      r_ap_start <= (r_state == ST_RUN) && (&w_in_vld);
    end
  end

  assign ap_start = (START_MODE == START_GATED) ? r_ap_start : (r_state == ST_RUN);

endmodule

// File: doc/leaf_user_bridge.md
Name: leaf_user_bridge

Overview:
- Parametrised elastic adapter between leaf_interface user-side ports and an HLS operator's ap_vld/ap_ack streams, all in the clk_user domain.
- Generalises the fixed 1-in/2-out wrapper wiring to N_IN/N_OUT channels.
- Adds a per-channel FIFO, a configurable ap_start sequencer and per-channel transfer counters.
- Instantiated inside each leaf between leaf_interface_inst and the operator instance.

Parameters:
PAYLOAD_BITS, 32, data width per channel
N_IN, 1, channels from interface to operator (1..15)
N_OUT, 2, channels from operator to interface (1..15)
DEPTH, 4, entries per channel FIFO; power of two, >=2
START_MODE, 0, 0 = ap_start high after START_DELAY; 1 = ap_start gated on all input FIFOs non-empty
START_DELAY, 8, cycles after reset release before ap_start may assert (0..255)
CNT_BITS, 16, width of each transfer counter

Ports:
clk_user  in  1  user clock; all logic on rising edge
reset  in  1  synchronous, active-high
din_if_data  in  N_IN*PAYLOAD_BITS  from dout_leaf_interface2user; channel i at [i*PB +: PB]
din_if_vld  in  N_IN  from vld_interface2user
din_if_ack  out  N_IN  to ack_user2interface
dout_op_data  out  N_IN*PAYLOAD_BITS  to operator Input_i
dout_op_vld  out  N_IN  to operator Input_i_ap_vld
dout_op_ack  in  N_IN  from operator Input_i_ap_ack
din_op_data  in  N_OUT*PAYLOAD_BITS  from operator Output_j
din_op_vld  in  N_OUT  from Output_j_ap_vld
din_op_ack  out  N_OUT  to Output_j_ap_ack
dout_if_data  out  N_OUT*PAYLOAD_BITS  to din_leaf_user2interface
dout_if_vld  out  N_OUT  to vld_user2interface
dout_if_ack  in  N_OUT  from ack_interface2user
ap_start  out  1  operator start
xfer_cnt  out  (N_IN+N_OUT)*CNT_BITS  accepted-word counters; inputs first, then outputs

Behaviour:
- Transfer rule: a word moves on a cycle where vld and ack are both high. Producers hold data and vld until acked.
- Each of the N_IN+N_OUT channels has an independent DEPTH-entry FIFO.
- Write side: ack = !full, from registered state only. No combinational path from vld to ack.
- Read side: first-word-fall-through. vld = !empty; data = head entry, stable while vld && !ack.
- Push-to-read latency: exactly 1 cycle. No bypass when empty.
- Full with simultaneous pop: ack stays low that cycle and the push is refused. Producer retries the next cycle.
- Empty: no pop is possible. A push that cycle produces vld on the next cycle.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- full = (MSBs differ && low bits equal); empty = pointers equal.
- Occupancy never exceeds DEPTH. Channels are fully independent, with no cross-channel ordering.
- Counters: xfer_cnt[k] increments on every accepted write into FIFO k and wraps at 2^CNT_BITS to 0.
- Start sequencer states: RST_WAIT -> RUN.
  - RST_WAIT: counts START_DELAY cycles after reset deasserts, then enters RUN. START_DELAY=0 enters RUN on the first cycle after reset.
  - Mode 0: ap_start = 1 in RUN.
  - Mode 1: ap_start = 1 in RUN only while every input FIFO is non-empty. Registered, so it updates the cycle after occupancy changes.
- Reset values (synchronous, any time, including mid-transfer):
  - all pointers 0, so all FIFOs empty and stored words are discarded;
  - all *_vld = 0, all *_ack = 1 on the first cycle after reset;
  - xfer_cnt = 0, ap_start = 0, state = RST_WAIT.
- While reset is high, ack outputs are 0 and no transfers are accepted.

Decomposition:
- Package leaf_bridge_pkg holds:
  - state enum {RST_WAIT, RUN};
  - localparam START_ALWAYS=0 and START_GATED=1;
  - function clog2 for pointer width.
- Sub-module leaf_chan_fifo (PAYLOAD_BITS, DEPTH, CNT_BITS) provides FIFO, handshake and counter. It is instantiated N_IN+N_OUT times via generate.
- The top holds the start sequencer and bus slicing.

Test Plan:
- Reset, then idle with mode 0 and START_DELAY=8 -> ap_start low for 8 cycles, high from cycle 9. All vld=0, ack=1, xfer_cnt=0.
- Push 0xA5A5_0001 on in-channel 0 with dout_op_ack=1 -> dout_op_vld high exactly 1 cycle after acceptance with the same data; xfer_cnt[0]=1.
- Out-channel 1: push 5 words (0x10..0x14) with dout_if_ack=0 and DEPTH=4 -> 4 accepted, din_op_ack low on the 5th. Set dout_if_ack=1 -> words drain in order 0x10..0x13, then 0x14 is accepted.
- Full FIFO with simultaneous push and pop -> push refused, pop succeeds, occupancy 3. Push accepted next cycle.
- Mode 1, N_IN=2, fill only channel 0 -> ap_start stays 0. Push to channel 1 -> ap_start=1 the following cycle. Drain channel 0 -> ap_start=0 one cycle later.
- Assert reset with 3 words queued -> next cycle all vld=0 and xfer_cnt=0. Preset the counter to 0xFFFF and push one word -> counter wraps to 0x0000.
